// File: rtl/i2c_multibyte_controller.sv
// I2C multi-byte transfer sequencer: START, address byte, N-1 data bytes with ACK slots, STOP, bus-free wait.
// Optional macro I2C_CTRL_ACK_CHECK_EN adds SDAIn/NackError and aborts a write transfer on slave NACK.
module i2c_multibyte_controller #(
  parameter int DATA_BITS       = 8,
  parameter int MAX_BYTES       = 4,
  parameter int BUS_FREE_CYCLES = 3,
  localparam int NB             = $clog2(MAX_BYTES + 1)
) (
  input  logic          clock,
  input  logic          Reset,
  input  logic          Go,
  input  logic          ClockI2C,
  input  logic [NB-1:0] NumBytes,
  input  logic          ReadMode,
`ifdef I2C_CTRL_ACK_CHECK_EN
  input  logic          SDAIn,
  output logic          NackError,
`endif
  output logic          WriteLoad,
  output logic          ReadorWrite,
  output logic          ShiftorHold,
  output logic          Select,
  output logic          BaudEnable,
  output logic          StartStopAck,
  output logic          Busy,
  output logic          Done
);

  // state | meaning
  // IDLE  | bus free, waiting for Go
  // START | SDA pulled low while SCL high
  // LOAD  | one cycle: load next TX byte, arm bit counter
  // XFER  | DATA_BITS data bits shifted out (write) or in (read)
  // ACK   | ninth clock: ACK/NACK slot
  // STOP  | SDA low, released while SCL high
  // WAIT  | bus-free time before Done
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] XFER  = 3'd3;
  localparam logic [2:0] ACK   = 3'd4;
  localparam logic [2:0] STOP  = 3'd5;
  localparam logic [2:0] WAIT  = 3'd6;

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int WW = (BUS_FREE_CYCLES > 1) ? $clog2(BUS_FREE_CYCLES) : 1;

  logic [2:0]    state;
  logic [2:0]    sclSync;
  logic          negPulse, posPulse;
  logic [NB-1:0] numLat, byteCnt, effBytes;
  logic          readLat;
  logic [BW-1:0] bitCnt;
  logic [WW-1:0] waitCnt;
  logic          doneReg;
  logic          isRead, lastByte, stopNow;
  logic [NB:0]   byteNext;

  // SCL idles high, so the synchroniser resets high to avoid a false falling edge
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      sclSync  <= 3'b111;
      negPulse <= 1'b0;
      posPulse <= 1'b0;
    end else begin
      sclSync  <= {sclSync[1:0], ClockI2C};
      negPulse <= sclSync[2] & ~sclSync[1];
      posPulse <= ~sclSync[2] & sclSync[1];
    end
  end

  always_comb begin
    effBytes = NumBytes;
    if (NumBytes == '0)
      effBytes = NB'(1);
    else if (NumBytes > NB'(MAX_BYTES))
      effBytes = NB'(MAX_BYTES);
  end

  assign isRead   = readLat && (byteCnt != '0);
  assign byteNext = {1'b0, byteCnt} + 1'b1;
  assign lastByte = byteNext >= {1'b0, numLat};

`ifdef I2C_CTRL_ACK_CHECK_EN
  logic [1:0] sdaSync;
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) sdaSync <= 2'b11;
    else       sdaSync <= {sdaSync[0], SDAIn};
  end
  assign stopNow = lastByte || NackError;
`else
  assign stopNow = lastByte;
`endif

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      numLat  <= '0;
      readLat <= 1'b0;
      byteCnt <= '0;
      bitCnt  <= '0;
      waitCnt <= '0;
      doneReg <= 1'b0;
`ifdef I2C_CTRL_ACK_CHECK_EN
      NackError <= 1'b0;
`endif
    end else begin
      doneReg <= 1'b0;
      case (state)
        IDLE: if (Go) begin
          numLat  <= effBytes;
          readLat <= ReadMode;
          byteCnt <= '0;
          state   <= START;
`ifdef I2C_CTRL_ACK_CHECK_EN
          NackError <= 1'b0;
`endif
        end
        START: if (negPulse) state <= LOAD;
        LOAD: begin
          bitCnt <= BW'(DATA_BITS);
          state  <= XFER;
        end
        XFER: begin
          if (ShiftorHold)
            bitCnt <= bitCnt - 1'b1;
          else if (bitCnt == '0 && negPulse)
            state <= ACK;
        end
        ACK: begin
`ifdef I2C_CTRL_ACK_CHECK_EN
          if (posPulse && !isRead && sdaSync[1]) NackError <= 1'b1;
`endif
          if (negPulse) begin
            byteCnt <= byteNext[NB-1:0];
            state   <= stopNow ? STOP : LOAD;
          end
        end
        STOP: if (posPulse) begin
          waitCnt <= WW'(BUS_FREE_CYCLES - 1);
          state   <= WAIT;
        end
        WAIT: begin
          if (waitCnt == '0) begin
            doneReg <= 1'b1;
            state   <= IDLE;
          end else begin
            waitCnt <= waitCnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    WriteLoad    = 1'b0;
    ReadorWrite  = 1'b0;
    ShiftorHold  = 1'b0;
    Select       = 1'b1;
    BaudEnable   = 1'b0;
    StartStopAck = 1'b1;
    Busy         = (state != IDLE);
    Done         = doneReg;
    case (state)
      START: begin
        StartStopAck = 1'b0;
        BaudEnable   = 1'b1;
      end
      LOAD: begin
        WriteLoad    = ~isRead;
        ReadorWrite  = isRead;
        StartStopAck = isRead;
        BaudEnable   = 1'b1;
      end
      XFER: begin
        ReadorWrite  = isRead;
        Select       = isRead;
        BaudEnable   = 1'b1;
        ShiftorHold  = (bitCnt != '0) && (isRead ? posPulse : negPulse);
      end
      ACK: begin
        // reads ACK every byte except the last, which is NACKed
        ReadorWrite  = isRead;
        StartStopAck = isRead ? lastByte : 1'b1;
        BaudEnable   = 1'b1;
      end
      STOP: begin
        StartStopAck = 1'b0;
        BaudEnable   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_i2c_multibyte_controller.sv
// Self-checking bench for i2c_multibyte_controller: per-transaction pulse counts checked against a scoreboard.
module tb_i2c_multibyte_controller;

  logic       clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Go = 1'b0;
  logic       ClockI2C = 1'b1;
  logic [2:0] NumBytes = 3'd0;
  logic       ReadMode = 1'b0;
  logic       WriteLoad, ReadorWrite, ShiftorHold, Select, BaudEnable, StartStopAck, Busy, Done;
`ifdef I2C_CTRL_ACK_CHECK_EN
  logic       SDAIn = 1'b0;
  logic       NackError;
`endif

  i2c_multibyte_controller dut (
    .clock(clock), .Reset(Reset), .Go(Go), .ClockI2C(ClockI2C),
    .NumBytes(NumBytes), .ReadMode(ReadMode),
`ifdef I2C_CTRL_ACK_CHECK_EN
    .SDAIn(SDAIn), .NackError(NackError),
`endif
    .WriteLoad(WriteLoad), .ReadorWrite(ReadorWrite), .ShiftorHold(ShiftorHold),
    .Select(Select), .BaudEnable(BaudEnable), .StartStopAck(StartStopAck),
    .Busy(Busy), .Done(Done)
  );

  always #4  clock = ~clock;
  always #24 ClockI2C = ~ClockI2C;

  typedef struct {
    int n;
    int rm;
    int wl;
    int shW;
    int shR;
    int ackLow;
  } vec_t;

  vec_t q[$];
  int nVec = 0, nErr = 0;
  int wl = 0, shW = 0, shR = 0, ackLow = 0, overlap = 0, doneCnt = 0;
  logic lowPrev = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: accumulate pulses per transaction, compare against scoreboard on Done
  always @(negedge clock) begin
    if (WriteLoad && ShiftorHold) overlap++;
    if (Reset) begin
      wl = 0; shW = 0; shR = 0; ackLow = 0; lowPrev = 1'b0;
    end else begin
      if (WriteLoad) wl++;
      if (ShiftorHold && !ReadorWrite) shW++;
      if (ShiftorHold && ReadorWrite) shR++;
      if ((ReadorWrite && !StartStopAck) && !lowPrev) ackLow++;
      lowPrev = ReadorWrite && !StartStopAck;
      if (Done) begin
        doneCnt++;
        check("busy_at_done", Busy, 0);
        if (q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          vec_t e;
          e = q.pop_front();
          check($sformatf("writeload n=%0d rm=%0d", e.n, e.rm), wl, e.wl);
          check($sformatf("shift_write n=%0d rm=%0d", e.n, e.rm), shW, e.shW);
          check($sformatf("shift_read n=%0d rm=%0d", e.n, e.rm), shR, e.shR);
          check($sformatf("ack_low n=%0d rm=%0d", e.n, e.rm), ackLow, e.ackLow);
        end
        wl = 0; shW = 0; shR = 0; ackLow = 0;
      end
    end
  end

  task automatic waitDone(input int startCnt);
    for (int c = 0; c < 4000 && doneCnt == startCnt; c++) @(negedge clock);
    check("done_within_budget", int'(doneCnt != startCnt), 1);
    repeat (2) @(negedge clock);
  endtask

  task automatic runTxn(input vec_t v);
    int s;
    @(negedge clock);
    s = doneCnt;
    NumBytes = 3'(v.n);
    ReadMode = v.rm[0];
    Go = 1'b1;
    q.push_back(v);
    @(negedge clock);
    Go = 1'b0;
    waitDone(s);
  endtask

  task automatic waitShift();
    for (int c = 0; c < 2000 && !ShiftorHold; c++) @(negedge clock);
    check("xfer_reached", ShiftorHold, 1);
  endtask

  vec_t tbl[8];
  vec_t v;
  int s;

  initial begin
    //        n  rm wl shW shR ackLow
    tbl[0] = '{1, 0, 1,  8,  0, 0};
    tbl[1] = '{3, 1, 1,  8, 16, 1};
    tbl[2] = '{0, 0, 1,  8,  0, 0};
    tbl[3] = '{7, 0, 4, 32,  0, 0};
    tbl[4] = '{4, 1, 1,  8, 24, 2};
    tbl[5] = '{2, 0, 2, 16,  0, 0};
    tbl[6] = '{7, 1, 1,  8, 24, 2};
    tbl[7] = '{2, 1, 1,  8,  8, 0};

    #1;
    check("reset_outputs",
          int'({WriteLoad, ReadorWrite, ShiftorHold, Select, BaudEnable, StartStopAck, Busy, Done}),
          int'(8'b0001_0100));
    repeat (3) @(negedge clock);
    Reset = 1'b0;
    repeat (3) @(negedge clock);

    for (int i = 0; i < 8; i++) runTxn(tbl[i]);

    // asynchronous reset in the middle of a data byte
    @(negedge clock);
    NumBytes = 3'd4; ReadMode = 1'b0; Go = 1'b1;
    @(negedge clock);
    Go = 1'b0;
    waitShift();
    s = doneCnt;
    #2 Reset = 1'b1;
    #1;
    check("reset_mid_xfer",
          int'({Select, BaudEnable, StartStopAck, Busy, Done}), int'(5'b10100));
    repeat (3) @(negedge clock);
    Reset = 1'b0;
    repeat (60) @(negedge clock);
    check("no_done_after_reset", doneCnt, s);
    check("idle_after_reset", Busy, 0);

    // Go and NumBytes changed mid-transfer are ignored
    @(negedge clock);
    s = doneCnt;
    NumBytes = 3'd2; ReadMode = 1'b0; Go = 1'b1;
    v = '{2, 0, 2, 16, 0, 0};
    q.push_back(v);
    @(negedge clock);
    Go = 1'b0;
    waitShift();
    NumBytes = 3'd4; ReadMode = 1'b1; Go = 1'b1;
    @(negedge clock);
    Go = 1'b0;
    waitDone(s);
    repeat (20) @(negedge clock);
    check("no_restart_after_toggle", Busy, 0);
    check("single_done_after_toggle", doneCnt, s + 1);

    // Go held high across Done: back-to-back transactions
    @(negedge clock);
    s = doneCnt;
    NumBytes = 3'd1; ReadMode = 1'b0; Go = 1'b1;
    v = '{1, 0, 1, 8, 0, 0};
    q.push_back(v);
    q.push_back(v);
    for (int c = 0; c < 4000 && !Done; c++) @(negedge clock);
    check("b2b_first_done", Done, 1);
    check("b2b_idle_on_done", Busy, 0);
    @(negedge clock);
    check("b2b_restart_next_cycle", Busy, 1);
    Go = 1'b0;
    waitDone(s + 1);
    check("b2b_two_dones", doneCnt, s + 2);

`ifdef I2C_CTRL_ACK_CHECK_EN
    SDAIn = 1'b1;
    v = '{3, 0, 1, 8, 0, 0};
    runTxn(v);
    check("nack_error_set", NackError, 1);
    SDAIn = 1'b0;
    v = '{1, 0, 1, 8, 0, 0};
    runTxn(v);
    check("nack_error_cleared", NackError, 0);
`endif

    check("shift_writeload_overlap", overlap, 0);
    check("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
